// File: rtl/cmos_capture_data.sv
// cmos_capture_data
// Turns the 8-bit camera byte stream into RGB565 pixels. Frames are ignored for
// WAIT_FRAME vsync pulses after reset, while the sensor configuration settles.
// Sync inputs go through a two-flop delay. Byte pairs are assembled high byte
// first. A line that ends on an odd byte is flagged.

module cmos_capture_data #(
   parameter logic [3:0] WAIT_FRAME = 4'd10
) (
   input  logic        cam_pclk,
   input  logic        rst_n,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   output logic        cmos_frame_vsync,
   output logic        cmos_frame_href,
   output logic        cmos_frame_valid,
   output logic [15:0] cmos_frame_data,
   output logic        cmos_line_err
);

   logic        vsyncD0_q, vsyncD1_q;
   logic        hrefD0_q, hrefD1_q;
   logic [3:0]  frameCnt_q, frameCnt_d;
   logic        frameValFlag_q, frameValFlag_d;
   logic        phase_q, phase_d;
   logic [7:0]  highByte_q, highByte_d;
   logic [15:0] pixData_q, pixData_d;
   logic        byteFlag_q, byteFlag_d;
   logic        byteFlagD0_q;
   logic        lineErr_q, lineErr_d;
   logic        posVsync;
   logic        oddLineEnd;

   assign posVsync = vsyncD0_q & ~vsyncD1_q;

   // The line is ending (href_d0 about to fall) while a high byte is still waiting for its partner
   assign oddLineEnd = hrefD0_q & ~cam_href & phase_q;

   // Next-state logic: warm-up frame counting and byte pairing driven by cam_href alone
   always_comb begin
      frameCnt_d     = frameCnt_q;
      frameValFlag_d = frameValFlag_q;
      phase_d        = 1'b0;
      highByte_d     = highByte_q;
      pixData_d      = pixData_q;
      byteFlag_d     = 1'b0;
      lineErr_d      = oddLineEnd;

      if (posVsync && (frameCnt_q < WAIT_FRAME))
         frameCnt_d = frameCnt_q + 4'd1;

      if (frameCnt_q == WAIT_FRAME)
         frameValFlag_d = 1'b1;

      if (cam_href) begin
         phase_d = ~phase_q;
         if (!phase_q) begin
            highByte_d = cam_data;
         end else begin
            pixData_d  = {highByte_q, cam_data};
            byteFlag_d = 1'b1;
         end
      end else if (oddLineEnd) begin
         highByte_d = 8'd0;
      end
   end

   // State registers; reset aborts any partial pixel and restarts the warm-up count
   always_ff @(posedge cam_pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsyncD0_q      <= 1'b0;
         vsyncD1_q      <= 1'b0;
         hrefD0_q       <= 1'b0;
         hrefD1_q       <= 1'b0;
         frameCnt_q     <= 4'd0;
         frameValFlag_q <= 1'b0;
         phase_q        <= 1'b0;
         highByte_q     <= 8'd0;
         pixData_q      <= 16'd0;
         byteFlag_q     <= 1'b0;
         byteFlagD0_q   <= 1'b0;
         lineErr_q      <= 1'b0;
      end else begin
         vsyncD0_q      <= cam_vsync;
         vsyncD1_q      <= vsyncD0_q;
         hrefD0_q       <= cam_href;
         hrefD1_q       <= hrefD0_q;
         frameCnt_q     <= frameCnt_d;
         frameValFlag_q <= frameValFlag_d;
         phase_q        <= phase_d;
         highByte_q     <= highByte_d;
         pixData_q      <= pixData_d;
         byteFlag_q     <= byteFlag_d;
         byteFlagD0_q   <= byteFlag_q;
         lineErr_q      <= lineErr_d;
      end
   end

   // Outputs are gated by the warm-up flag, except the line error, which always reports
   assign cmos_frame_vsync = vsyncD1_q & frameValFlag_q;
   assign cmos_frame_href  = hrefD1_q & frameValFlag_q;
   assign cmos_frame_valid = byteFlagD0_q & frameValFlag_q;
   assign cmos_frame_data  = frameValFlag_q ? pixData_q : 16'd0;
   assign cmos_line_err    = lineErr_q;

endmodule

// File: tb/tb_cmos_capture_data.sv
// tb_cmos_capture_data
// Scoreboard bench. The stimulus tasks push each expected pixel when its second
// byte is driven. A negedge monitor pops the pixel when the strobe appears.

module tb_cmos_capture_data;

   localparam int WAIT = 10;

   typedef struct {
      logic [15:0] data;
      int          sampleEdge;
   } pixel_t;

   logic        cam_pclk = 1'b0;
   logic        rst_n;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        cmos_frame_vsync;
   logic        cmos_frame_href;
   logic        cmos_frame_valid;
   logic [15:0] cmos_frame_data;
   logic        cmos_line_err;

   int     total = 0;
   int     bad = 0;
   int     edgeCnt = 0;
   int     popCnt = 0;
   int     errCnt = 0;
   int     noisyCycles = 0;
   int     syncMiss = 0;
   int     valDrops = 0;
   int     vsyncSeen = 0;
   int     vsyncAtByte = -1;
   bit     silent = 1'b0;
   bit     trackSync = 1'b0;
   bit     trackVal = 1'b0;
   logic [1:0] vsHist = 2'b00;
   logic [1:0] hrHist = 2'b00;
   logic [7:0] hiModel;
   logic [7:0] lineBuf[$];
   pixel_t     expQ[$];

   cmos_capture_data #(.WAIT_FRAME(4'd10)) dut (
      .cam_pclk         (cam_pclk),
      .rst_n            (rst_n),
      .cam_vsync        (cam_vsync),
      .cam_href         (cam_href),
      .cam_data         (cam_data),
      .cmos_frame_vsync (cmos_frame_vsync),
      .cmos_frame_href  (cmos_frame_href),
      .cmos_frame_valid (cmos_frame_valid),
      .cmos_frame_data  (cmos_frame_data),
      .cmos_line_err    (cmos_line_err)
   );

   // 10 ns pixel clock
   always #5 cam_pclk = ~cam_pclk;

   // Edge counter plus the sync values each edge sampled, for the 2-cycle delay check
   always @(posedge cam_pclk) begin
      edgeCnt <= edgeCnt + 1;
      vsHist  <= {vsHist[0], cam_vsync};
      hrHist  <= {hrHist[0], cam_href};
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor, half a cycle away from the active edge
   always @(negedge cam_pclk) begin
      pixel_t p;
      if (cmos_frame_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedStrobe", 32'd1, 32'd0);
         end else begin
            p = expQ.pop_front();
            popCnt++;
            checkOutput("pixelData", {16'd0, cmos_frame_data}, {16'd0, p.data});
            // Strobe is visible the cycle after the next edge, so a downstream flop takes it 2 edges after sampling
            checkOutput("strobeLatency", edgeCnt - p.sampleEdge, 32'd1);
         end
      end
      if (cmos_line_err) errCnt++;
      if (silent && (cmos_frame_valid || cmos_frame_href)) noisyCycles++;
      if (trackSync && ((cmos_frame_vsync !== vsHist[1]) || (cmos_frame_href !== hrHist[1]))) syncMiss++;
      if (trackVal && (dut.frameValFlag_q !== 1'b1)) valDrops++;
   end

   task automatic tick();
      @(posedge cam_pclk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit second);
      cam_href = 1'b1;
      cam_data = b;
      tick();
      if (!second) begin
         hiModel = b;
      end else if (vsyncSeen >= WAIT) begin
         expQ.push_back('{data: {hiModel, b}, sampleEdge: edgeCnt});
      end
   endtask

   task automatic sendLine();
      for (int i = 0; i < lineBuf.size(); i++) begin
         if (i == vsyncAtByte) cam_vsync = 1'b1;
         if (i == vsyncAtByte + 2) cam_vsync = 1'b0;
         applyStimulus(lineBuf[i], (i % 2) == 1);
      end
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      repeat (4) tick();
   endtask

   task automatic sendFrame(input int lines, input int bytesPerLine);
      for (int l = 0; l < lines; l++) begin
         lineBuf.delete();
         for (int b = 0; b < bytesPerLine; b++) lineBuf.push_back(8'($urandom_range(0, 255)));
         sendLine();
      end
      cam_vsync = 1'b1;
      repeat (3) tick();
      cam_vsync = 1'b0;
      vsyncSeen++;
      repeat (3) tick();
   endtask

   initial begin
      int popBase;
      int errBase;
      rst_n     = 1'b0;
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      repeat (3) tick();

      checkOutput("resetVsync", {31'd0, cmos_frame_vsync}, 32'd0);
      checkOutput("resetHref", {31'd0, cmos_frame_href}, 32'd0);
      checkOutput("resetValid", {31'd0, cmos_frame_valid}, 32'd0);
      checkOutput("resetData", {16'd0, cmos_frame_data}, 32'd0);
      checkOutput("resetLineErr", {31'd0, cmos_line_err}, 32'd0);

      rst_n = 1'b1;
      tick();

      silent = 1'b1;
      for (int f = 0; f < WAIT; f++) sendFrame(4, 8);
      silent = 1'b0;
      checkOutput("warmupSilent", noisyCycles, 32'd0);
      checkOutput("warmupCount", {28'd0, dut.frameCnt_q}, 32'd10);
      checkOutput("warmupNoLineErr", errCnt, 32'd0);

      trackSync = 1'b1;
      trackVal  = 1'b1;
      popBase = popCnt;
      sendFrame(4, 8);
      checkOutput("frame11Strobes", popCnt - popBase, 32'd16);

      popBase = popCnt;
      lineBuf = '{8'hF8, 8'h00, 8'h07, 8'hE0};
      vsyncAtByte = 1;
      sendLine();
      vsyncAtByte = -1;
      checkOutput("pairStrobes", popCnt - popBase, 32'd2);

      popBase = popCnt;
      errBase = errCnt;
      lineBuf = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      sendLine();
      checkOutput("oddStrobes", popCnt - popBase, 32'd2);
      checkOutput("oddLineErr", errCnt - errBase, 32'd1);
      lineBuf = '{8'h12, 8'h34};
      sendLine();
      checkOutput("afterOddStrobes", popCnt - popBase, 32'd3);
      checkOutput("afterOddLineErr", errCnt - errBase, 32'd1);

      for (int f = 0; f < 20; f++) sendFrame(1, 2);
      checkOutput("saturatedCount", {28'd0, dut.frameCnt_q}, 32'd10);
      checkOutput("flagNeverDrops", valDrops, 32'd0);
      checkOutput("syncTracking", syncMiss, 32'd0);
      checkOutput("queueDrained", expQ.size(), 32'd0);

      trackSync = 1'b0;
      trackVal  = 1'b0;
      applyStimulus(8'h5A, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("midResetVsync", {31'd0, cmos_frame_vsync}, 32'd0);
      checkOutput("midResetHref", {31'd0, cmos_frame_href}, 32'd0);
      checkOutput("midResetValid", {31'd0, cmos_frame_valid}, 32'd0);
      checkOutput("midResetData", {16'd0, cmos_frame_data}, 32'd0);
      checkOutput("midResetCount", {28'd0, dut.frameCnt_q}, 32'd0);
      cam_href = 1'b0;
      cam_data = 8'h00;
      vsyncSeen = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      noisyCycles = 0;
      silent = 1'b1;
      for (int f = 0; f < WAIT; f++) sendFrame(2, 4);
      silent = 1'b0;
      checkOutput("postResetSilent", noisyCycles, 32'd0);

      popBase = popCnt;
      lineBuf = '{8'hCA, 8'hFE, 8'hBE, 8'hEF};
      sendLine();
      checkOutput("recoveryStrobes", popCnt - popBase, 32'd2);

      repeat (10) tick();
      checkOutput("finalQueueEmpty", expQ.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmos_capture_data.md
CMOS_CAPTURE_DATA -- requirements
Module: cmos_capture_data

Interface
REQ-001 Parameter WAIT_FRAME, default 4'd10: number of camera frames discarded after reset while the sensor register configuration settles.
REQ-002 Port cam_pclk, input, 1: camera pixel clock; the only clock.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port cam_vsync, input, 1: sensor frame sync, active high.
REQ-005 Port cam_href, input, 1: sensor line valid, active high.
REQ-006 Port cam_data, input, 8: sensor byte stream, RGB565 high byte first.
REQ-007 Port cmos_frame_vsync, output, 1: gated, delayed frame sync to the downstream crop stage.
REQ-008 Port cmos_frame_href, output, 1: gated, delayed line valid.
REQ-009 Port cmos_frame_valid, output, 1: one-cycle strobe marking a completed 16-bit pixel.
REQ-010 Port cmos_frame_data, output, 16: assembled RGB565 pixel.
REQ-011 Port cmos_line_err, output, 1: one-cycle pulse when a line ends on an odd byte.

Function
REQ-012 cam_vsync and cam_href SHALL each pass through two flops (d0, d1); pos_vsync = d0 & ~d1.
REQ-013 Frame counter (4 bits) SHALL increment on each pos_vsync while it is below WAIT_FRAME, then saturate at WAIT_FRAME.
REQ-014 frame_val_flag SHALL set on the cycle after the counter equals WAIT_FRAME and SHALL remain set until reset.
REQ-015 Byte phase bit SHALL be 0 whenever cam_href is low, and SHALL toggle on every cam_pclk edge that samples cam_href=1.
REQ-016 Phase 0 with href=1: the sampled cam_data SHALL be stored as the high byte.
REQ-017 Phase 1 with href=1: pix_data SHALL load {high byte, cam_data}, and byte_flag SHALL assert for exactly one cycle.
REQ-018 byte_flag SHALL be delayed by one flop to form byte_flag_d0.
REQ-019 cmos_frame_valid = byte_flag_d0 & frame_val_flag. It is therefore high for one cycle, two edges after the edge that sampled the second byte.
REQ-020 cmos_frame_data = pix_data when frame_val_flag is set, else 16'd0. It SHALL be stable through every cycle in which cmos_frame_valid is high.
REQ-021 cmos_frame_vsync = vsync_d1 & frame_val_flag; cmos_frame_href = href_d1 & frame_val_flag.
REQ-022 Odd-byte line: if href_d0 falls while the phase is 1, the pending high byte SHALL be discarded and no valid strobe issued.
REQ-023 In the odd-byte case, cmos_line_err SHALL pulse for one cycle on the cycle following the falling edge, independent of frame_val_flag.
REQ-024 A line of 2N bytes SHALL produce exactly N valid strobes. Back-to-back pixels SHALL produce a strobe every second cycle.
REQ-025 A vsync edge arriving mid-line SHALL NOT alter byte pairing; pairing depends only on cam_href.
REQ-026 All arithmetic SHALL be unsigned. The frame counter SHALL never wrap.

Reset
REQ-027 Asserting rst_n low SHALL clear, asynchronously: all sync delay flops, the frame counter, frame_val_flag, the phase bit, the high-byte register, pix_data, byte_flag, byte_flag_d0 and cmos_line_err.
REQ-028 As a result, every output SHALL read 0 during reset.
REQ-029 Reset asserted mid-frame or mid-line SHALL abort the partial pixel; after release the WAIT_FRAME count SHALL restart from 0.
REQ-030 After release, no output SHALL go active before WAIT_FRAME fresh pos_vsync events.

Verification
REQ-031 Warm-up: WAIT_FRAME=10, send 10 frames of 4 lines x 8 bytes -> cmos_frame_valid and cmos_frame_href stay 0 throughout; the 11th frame produces 16 strobes.
REQ-032 Pixel pairing: after warm-up, bytes 0xF8,0x00,0x07,0xE0 -> strobes carry 0xF800 then 0x07E0; each strobe occurs 2 edges after the second byte is sampled.
REQ-033 Odd line: 5 bytes A1,B2,C3,D4,E5 -> exactly 2 strobes (0xA1B2, 0xC3D4); cmos_line_err pulses once; the next line restarts at phase 0.
REQ-034 Reset mid-line: drop rst_n after the high byte of a pixel -> all outputs 0 immediately; after release, outputs stay silent for 10 frames.
REQ-035 Sync gating: after warm-up, cmos_frame_vsync and cmos_frame_href track cam_vsync and cam_href delayed by exactly 2 cycles.
REQ-036 Saturation: run 20 frames -> the frame counter holds at 10 and frame_val_flag never drops.
